// File: rtl/packet_distributor_if.sv
// Bundle of the word-stream input and the two per-engine row outputs of the
// packet distributor. The slave modport is the distributor's view; the master
// modport is the view of whatever feeds the stream and consumes the rows.
interface packet_distributor_if #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 8
);

  // Input word stream
  logic [WORD_W-1:0]               s_data;
  logic                            s_valid;
  logic                            s_ready;

  // Engine 1 row port
  logic [WORD_W*WORDS_PER_ROW-1:0] m1_data;
  logic [WORDS_PER_ROW-1:0]        m1_keep;
  logic                            m1_last;
  logic                            m1_valid;
  logic                            m1_ready;

  // Engine 2 row port
  logic [WORD_W*WORDS_PER_ROW-1:0] m2_data;
  logic [WORDS_PER_ROW-1:0]        m2_keep;
  logic                            m2_last;
  logic                            m2_valid;
  logic                            m2_ready;

  // Sticky status
  logic                            err_zero_len;

  modport slave (
    input  s_data, s_valid,
    output s_ready,
    output m1_data, m1_keep, m1_last, m1_valid,
    input  m1_ready,
    output m2_data, m2_keep, m2_last, m2_valid,
    input  m2_ready,
    output err_zero_len
  );

  modport master (
    output s_data, s_valid,
    input  s_ready,
    input  m1_data, m1_keep, m1_last, m1_valid,
    output m1_ready,
    input  m2_data, m2_keep, m2_last, m2_valid,
    output m2_ready,
    input  err_zero_len
  );

endinterface

// File: rtl/packet_distributor.sv
// Packet distributor: splits a stream of length-prefixed packets (one header
// word carrying the byte length, then payload words) into rows of
// WORDS_PER_ROW words and hands whole packets alternately to engine 1 and
// engine 2. A row is assembled in a private buffer and copied into the
// selected engine's output registers only when it is complete, so a partial
// row is never visible downstream and a reset simply drops it.
module packet_distributor #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_ROW = 8,
  parameter int LEN_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  packet_distributor_if.slave  bus
);

  localparam int ROW_W = WORD_W * WORDS_PER_ROW;
  localparam int IDX_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  // One extra bit so that len+3 cannot wrap for the largest length.
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Registered state
  state_t                   r_state;
  logic                     r_eng;        // 0 = engine 1, 1 = engine 2
  logic [IDX_W-1:0]         r_idx;        // next word slot in the row
  logic [CNT_W-1:0]         r_rem;        // payload words still to accept
  logic [ROW_W-1:0]         r_buf;        // row under assembly
  logic [WORDS_PER_ROW-1:0] r_kbuf;       // fill mask of the row under assembly
  logic [ROW_W-1:0]         r_m1_data;
  logic [WORDS_PER_ROW-1:0] r_m1_keep;
  logic                     r_m1_last;
  logic                     r_m1_valid;
  logic [ROW_W-1:0]         r_m2_data;
  logic [WORDS_PER_ROW-1:0] r_m2_keep;
  logic                     r_m2_last;
  logic                     r_m2_valid;
  logic                     r_err;

  // Next-state values
  state_t                   w_state_nxt;
  logic                     w_eng_nxt;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic [CNT_W-1:0]         w_rem_nxt;
  logic [ROW_W-1:0]         w_buf_nxt;
  logic [WORDS_PER_ROW-1:0] w_kbuf_nxt;
  logic [ROW_W-1:0]         w_m1_data_nxt;
  logic [WORDS_PER_ROW-1:0] w_m1_keep_nxt;
  logic                     w_m1_last_nxt;
  logic                     w_m1_valid_nxt;
  logic [ROW_W-1:0]         w_m2_data_nxt;
  logic [WORDS_PER_ROW-1:0] w_m2_keep_nxt;
  logic                     w_m2_last_nxt;
  logic                     w_m2_valid_nxt;
  logic                     w_err_nxt;

  // Header decode and row-completion helpers
  logic [CNT_W-1:0]         w_len_ext;
  logic [CNT_W-1:0]         w_word_cnt;
  logic                     w_row_done;
  logic                     w_sel_ready;
  logic                     w_sel_last;
  logic                     w_last_word;

  assign w_len_ext   = {1'b0, bus.s_data[LEN_W-1:0]};
  assign w_word_cnt  = (w_len_ext + CNT_W'(3)) >> 2;
  assign w_last_word = (r_rem == CNT_W'(1));
  assign w_row_done  = (r_idx == IDX_W'(WORDS_PER_ROW - 1)) || w_last_word;
  assign w_sel_ready = r_eng ? bus.m2_ready : bus.m1_ready;
  assign w_sel_last  = r_eng ? r_m2_last : r_m1_last;

  // s_ready comes only from registered state, never from the engines' ready.
  assign bus.s_ready      = (!reset) && (r_state != ST_SEND);
  assign bus.m1_data      = r_m1_data;
  assign bus.m1_keep      = r_m1_keep;
  assign bus.m1_last      = r_m1_last;
  assign bus.m1_valid     = r_m1_valid;
  assign bus.m2_data      = r_m2_data;
  assign bus.m2_keep      = r_m2_keep;
  assign bus.m2_last      = r_m2_last;
  assign bus.m2_valid     = r_m2_valid;
  assign bus.err_zero_len = r_err;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, row assembly and output-row decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_eng_nxt      = r_eng;
    w_idx_nxt      = r_idx;
    w_rem_nxt      = r_rem;
    w_buf_nxt      = r_buf;
    w_kbuf_nxt     = r_kbuf;
    w_m1_data_nxt  = r_m1_data;
    w_m1_keep_nxt  = r_m1_keep;
    w_m1_last_nxt  = r_m1_last;
    w_m1_valid_nxt = r_m1_valid;
    w_m2_data_nxt  = r_m2_data;
    w_m2_keep_nxt  = r_m2_keep;
    w_m2_last_nxt  = r_m2_last;
    w_m2_valid_nxt = r_m2_valid;
    w_err_nxt      = r_err;

    case (r_state)
      ST_IDLE: begin
        if (bus.s_valid) begin
          if (w_len_ext == CNT_W'(0)) begin
            // Empty packet: flag it, emit nothing, engine turn unchanged.
            w_err_nxt = 1'b1;
          end else begin
            w_rem_nxt   = w_word_cnt;
            w_idx_nxt   = IDX_W'(0);
            w_buf_nxt   = ROW_W'(0);
            w_kbuf_nxt  = WORDS_PER_ROW'(0);
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (bus.s_valid) begin
          w_buf_nxt[r_idx*WORD_W +: WORD_W] = bus.s_data;
          w_kbuf_nxt[r_idx]                 = 1'b1;
          w_rem_nxt                         = r_rem - CNT_W'(1);
          if (w_row_done) begin
            // Publish the finished row to the engine whose turn it is.
            if (r_eng == 1'b0) begin
              w_m1_data_nxt  = w_buf_nxt;
              w_m1_keep_nxt  = w_kbuf_nxt;
              w_m1_last_nxt  = w_last_word;
              w_m1_valid_nxt = 1'b1;
            end else begin
              w_m2_data_nxt  = w_buf_nxt;
              w_m2_keep_nxt  = w_kbuf_nxt;
              w_m2_last_nxt  = w_last_word;
              w_m2_valid_nxt = 1'b1;
            end
            w_idx_nxt   = IDX_W'(0);
            w_buf_nxt   = ROW_W'(0);
            w_kbuf_nxt  = WORDS_PER_ROW'(0);
            w_state_nxt = ST_SEND;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_state_nxt = ST_FILL;
        end
      end

      ST_SEND: begin
        if (w_sel_ready) begin
          // keep/last are cleared on every handshake so an engine that is no
          // longer selected never shows a stale mask or last flag.
          if (r_eng == 1'b0) begin
            w_m1_valid_nxt = 1'b0;
            w_m1_keep_nxt  = WORDS_PER_ROW'(0);
            w_m1_last_nxt  = 1'b0;
            if (!w_sel_last) begin
              w_m1_data_nxt = ROW_W'(0);
            end else begin
              w_m1_data_nxt = r_m1_data;
            end
          end else begin
            w_m2_valid_nxt = 1'b0;
            w_m2_keep_nxt  = WORDS_PER_ROW'(0);
            w_m2_last_nxt  = 1'b0;
            if (!w_sel_last) begin
              w_m2_data_nxt = ROW_W'(0);
            end else begin
              w_m2_data_nxt = r_m2_data;
            end
          end
          if (w_sel_last) begin
            w_eng_nxt   = ~r_eng;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_SEND;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eng      <= 1'b0;
      r_idx      <= IDX_W'(0);
      r_rem      <= CNT_W'(0);
      r_buf      <= ROW_W'(0);
      r_kbuf     <= WORDS_PER_ROW'(0);
      r_m1_data  <= ROW_W'(0);
      r_m1_keep  <= WORDS_PER_ROW'(0);
      r_m1_last  <= 1'b0;
      r_m1_valid <= 1'b0;
      r_m2_data  <= ROW_W'(0);
      r_m2_keep  <= WORDS_PER_ROW'(0);
      r_m2_last  <= 1'b0;
      r_m2_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_eng      <= w_eng_nxt;
      r_idx      <= w_idx_nxt;
      r_rem      <= w_rem_nxt;
      r_buf      <= w_buf_nxt;
      r_kbuf     <= w_kbuf_nxt;
      r_m1_data  <= w_m1_data_nxt;
      r_m1_keep  <= w_m1_keep_nxt;
      r_m1_last  <= w_m1_last_nxt;
      r_m1_valid <= w_m1_valid_nxt;
      r_m2_data  <= w_m2_data_nxt;
      r_m2_keep  <= w_m2_keep_nxt;
      r_m2_last  <= w_m2_last_nxt;
      r_m2_valid <= w_m2_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_packet_distributor.sv
// Directed bench for packet_distributor: a table of packets with
// hand-computed engine, row count and final-row keep mask, plus hand-written
// sequences for back-pressure, zero-length headers and reset mid-packet.
module tb_packet_distributor;

  localparam int WORD_W = 32;
  localparam int WPR    = 8;
  localparam int LEN_W  = 16;
  localparam int ROW_W  = WORD_W * WPR;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  packet_distributor_if #(.WORD_W(WORD_W), .WORDS_PER_ROW(WPR)) bus ();

  packet_distributor #(.WORD_W(WORD_W), .WORDS_PER_ROW(WPR), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] len;
    int          eng;        // 1 or 2
    int          rows;
    logic [7:0]  last_keep;
  } vec_t;

  vec_t vecs[7];

  // One comparison
  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present one word at a negedge and hold it until the DUT is ready
  task automatic push(input logic [31:0] w);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) timeout_fail("push_wait");
  endtask

  function automatic logic [ROW_W-1:0] row_data(input logic [31:0] base, input int nw, input int r);
    logic [ROW_W-1:0] d;
    d = '0;
    for (int j = 0; j < WPR; j++) begin
      if (r * WPR + j < nw) d[j*WORD_W +: WORD_W] = base + 32'(r * WPR + j);
    end
    return d;
  endfunction

  // Wait for one row on the given engine and check it
  task automatic check_row(input int eng, input logic [ROW_W-1:0] ed, input logic [7:0] ek,
                           input logic el, input int stall);
    int               guard;
    logic [ROW_W-1:0] d0;
    logic [7:0]       k0;
    logic             l0;
    logic             ok;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (((eng == 1) ? bus.m1_valid : bus.m2_valid) !== 1'b1 && guard < 200);
    if (guard >= 200) begin
      timeout_fail("row_wait");
      return;
    end
    d0 = (eng == 1) ? bus.m1_data : bus.m2_data;
    k0 = (eng == 1) ? bus.m1_keep : bus.m2_keep;
    l0 = (eng == 1) ? bus.m1_last : bus.m2_last;
    chk("row_data", d0, ed);
    chk("row_keep", ROW_W'(k0), ROW_W'(ek));
    chk("row_last", ROW_W'(l0), ROW_W'(el));
    chk("other_valid", ROW_W'((eng == 1) ? bus.m2_valid : bus.m1_valid), ROW_W'(1'b0));
    chk("other_keep", ROW_W'((eng == 1) ? bus.m2_keep : bus.m1_keep), ROW_W'(8'h00));
    if (stall > 0) begin
      chk("s_ready_in_send", ROW_W'(bus.s_ready), ROW_W'(1'b0));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (eng == 1)
          ok = (bus.m1_valid === 1'b1) && (bus.m1_data === d0) && (bus.m1_keep === k0) &&
               (bus.m1_last === l0) && (bus.s_ready === 1'b0);
        else
          ok = (bus.m2_valid === 1'b1) && (bus.m2_data === d0) && (bus.m2_keep === k0) &&
               (bus.m2_last === l0) && (bus.s_ready === 1'b0);
        chk("stall_hold", ROW_W'(ok), ROW_W'(1'b1));
      end
      if (eng == 1) bus.m1_ready = 1'b1;
      else          bus.m2_ready = 1'b1;
    end
    @(negedge clk);
    chk("valid_one_cycle", ROW_W'((eng == 1) ? bus.m1_valid : bus.m2_valid), ROW_W'(1'b0));
  endtask

  // Send one packet and check every row it produces
  task automatic run_pkt(input logic [15:0] len, input int eng, input int rows,
                         input logic [7:0] last_keep, input int stall, input logic [31:0] base);
    int nw;
    nw = (int'(len) + 3) >> 2;
    if (stall > 0) begin
      if (eng == 1) bus.m1_ready = 1'b0;
      else          bus.m2_ready = 1'b0;
    end
    fork
      begin
        push({16'hDEAD, len});
        for (int i = 0; i < nw; i++) push(base + 32'(i));
        @(negedge clk);
        bus.s_valid = 1'b0;
      end
      begin
        for (int r = 0; r < rows; r++)
          check_row(eng, row_data(base, nw, r), (r == rows - 1) ? last_keep : 8'hFF,
                    (r == rows - 1), (r == 0) ? stall : 0);
      end
    join
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_s_ready"}, ROW_W'(bus.s_ready), ROW_W'(1'b0));
    chk({name, "_valids"}, ROW_W'({bus.m1_valid, bus.m2_valid}), ROW_W'(2'b00));
    chk({name, "_keeps"}, ROW_W'({bus.m1_keep, bus.m2_keep}), ROW_W'(16'h0000));
    chk({name, "_lasts"}, ROW_W'({bus.m1_last, bus.m2_last}), ROW_W'(2'b00));
    chk({name, "_m1_data"}, bus.m1_data, ROW_W'(0));
    chk({name, "_m2_data"}, bus.m2_data, ROW_W'(0));
    chk({name, "_err"}, ROW_W'(bus.err_zero_len), ROW_W'(1'b0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 16'd8,     eng: 1, rows: 1,    last_keep: 8'h03};
    vecs[1] = '{len: 16'd40,    eng: 2, rows: 2,    last_keep: 8'h03};
    vecs[2] = '{len: 16'd4,     eng: 1, rows: 1,    last_keep: 8'h01};
    vecs[3] = '{len: 16'd5,     eng: 2, rows: 1,    last_keep: 8'h03};
    vecs[4] = '{len: 16'd33,    eng: 1, rows: 2,    last_keep: 8'h01};
    vecs[5] = '{len: 16'd32,    eng: 2, rows: 1,    last_keep: 8'hFF};
    vecs[6] = '{len: 16'd65535, eng: 1, rows: 2048, last_keep: 8'hFF};

    reset        = 1'b1;
    bus.s_data   = 32'h0;
    bus.s_valid  = 1'b0;
    bus.m1_ready = 1'b1;
    bus.m2_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", ROW_W'(bus.s_ready), ROW_W'(1'b1));

    // Table of packets with ready held high
    for (int p = 0; p < 7; p++)
      run_pkt(vecs[p].len, vecs[p].eng, vecs[p].rows, vecs[p].last_keep, 0, 32'(p + 1) << 24);

    // Back-pressure on the first row of a two-row packet (engine 2's turn)
    run_pkt(16'd40, 2, 2, 8'h03, 5, 32'hB000_0000);

    // Zero-length header: flag only, no row, engine turn unchanged
    push({16'hBEEF, 16'd0});
    @(negedge clk);
    bus.s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("zero_len_no_row", ROW_W'({bus.m1_valid, bus.m2_valid}), ROW_W'(2'b00));
      @(negedge clk);
    end
    chk("zero_len_err", ROW_W'(bus.err_zero_len), ROW_W'(1'b1));
    run_pkt(16'd4, 1, 1, 8'h01, 0, 32'hC000_0000);
    chk("zero_len_err_sticky", ROW_W'(bus.err_zero_len), ROW_W'(1'b1));

    // Reset after three payload words of a 32-byte packet (engine 2's turn)
    push({16'hDEAD, 16'd32});
    for (int i = 0; i < 3; i++) push(32'hD000_0000 + 32'(i));
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_no_row", ROW_W'({bus.m1_valid, bus.m2_valid}), ROW_W'(2'b00));
    run_pkt(16'd8, 1, 1, 8'h03, 0, 32'hE000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_distributor.md
# packet_distributor

Splits a single 32-bit word stream of length-prefixed packets back into 256-bit rows for two downstream engines, sending whole packets to each engine in turn. It is the receive-side counterpart of the two-engine aggregator: the aggregator merges per-engine 256-bit rows into one stream, and this block undoes that merge at the far end of the link.

## Interface
- WORD_W, 32, stream word width; one block of a row
- WORDS_PER_ROW, 8, words per output row; row width = WORD_W*WORDS_PER_ROW
- LEN_W, 16, width of the byte-length field in the header word
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_data  in  WORD_W  input stream word
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts s_data this cycle
- m1_data / m2_data  out  WORD_W*WORDS_PER_ROW  row to engine 1 / engine 2
- m1_keep / m2_keep  out  WORDS_PER_ROW  per-word valid mask for the row
- m1_last / m2_last  out  1  row is the final row of its packet
- m1_valid / m2_valid  out  1  row valid
- m1_ready / m2_ready  in  1  engine accepts row
- err_zero_len  out  1  sticky flag: a zero-length header was received

## Operation
- Packet format: one header word, then payload words. Header bits [LEN_W-1:0] hold the payload length in bytes. The remaining header bits are ignored.
- Payload word count = (len+3)>>2. Compute it at LEN_W+1 bits so the +3 cannot overflow.
- Word packing: payload word i of a row goes to bits [WORD_W*(i+1)-1 : WORD_W*i], with word 0 in the LSBs. keep[i]=1 for each filled word. Unfilled words are driven as 0.
- Engine pointer `eng` starts at 0 (engine 1). Every row of a packet goes to the engine `eng` selects. `eng` toggles after the handshake of the row with last=1.
- State IDLE: s_ready=1. On s_valid, latch the header and compute `remaining`.
  - If len==0: set err_zero_len, emit no row, leave `eng` unchanged, stay in IDLE.
  - Otherwise go to FILL with the row word index `idx` cleared.
- State FILL: s_ready=1. Each accepted word is written at `idx`, `idx` increments, and `remaining` decrements.
  - When `idx` reaches WORDS_PER_ROW-1 or `remaining` reaches 1, the accepting edge registers the row, keep, last (=remaining==1) and the selected valid, then moves to SEND.
- State SEND: s_ready=0. The selected m*_valid is held high. data, keep and last stay stable until the selected m*_ready is seen high.
  - On that handshake, clear valid.
  - If last: toggle `eng` and go to IDLE. Otherwise clear keep and data, then go to FILL.
- The unselected engine's valid, last and keep stay 0 at all times.
- Reset at any point: abandon any partial packet; no partial row is ever emitted. Return to IDLE with eng=0.

## Timing
- Reset values: s_ready=0 while reset is high, m*_data=0, m*_keep=0, m*_last=0, m*_valid=0, err_zero_len=0, state IDLE, eng=0, idx=0.
- s_ready is decoded from registered state, gated with !reset. It has no combinational path from m*_ready.
- Latency: the last word of a row is accepted at edge k, and m*_valid is high in the cycle after edge k.
- Throughput: a full row takes 8 FILL cycles plus at least 1 SEND cycle. Each packet adds 1 header cycle.
- SEND entered with ready already high completes in 1 cycle; FILL, or IDLE after a last row, follows at the next edge.
- A row is never overwritten while valid is high.
- Back-to-back packets: a new header can be accepted in the cycle after the final-row handshake.
- err_zero_len clears only on reset.

## Test plan
- Len=8, words A,B, m1_ready=1 → one row on engine 1: m1_data[63:0]={B,A}, upper bits 0, keep=8'h03, last=1, m1_valid high 1 cycle; m2_valid stays 0.
- Len=40 (10 words) → engine 1 row 0 keep=8'hFF last=0, then row 1 keep=8'h03 last=1. Next packet, len=4, goes to engine 2: keep=8'h01, last=1.
- Len=5 → 2 words, keep=8'h03. Len=65535 → 16384 words, 2048 rows, last set only on row 2047.
- Hold m1_ready=0 for 5 cycles during SEND → m1_data/keep/last stable, s_ready=0 for those cycles, no words lost; row completes the cycle after ready rises.
- Header len=0 → no m*_valid, err_zero_len=1 and stays 1. The following len=4 packet still goes to engine 1.
- Assert reset after 3 payload words of a len=32 packet → no row emitted, all outputs at reset values. A fresh len=8 packet after reset goes to engine 1 with keep=8'h03.
